// File: rtl/bomb_exp_module.sv
// Bomb placement, fuse/explosion timing and per-pixel bomb/explosion coverage.
// One bomb at a time; explosion arms are clipped by pillars and the arena edge.
module bomb_exp_module #(
  parameter int unsigned X_WALL_L   = 48,
  parameter int unsigned Y_WALL_U   = 31,
  parameter int unsigned TILE_WH    = 16,
  parameter int unsigned ARENA_W    = 33,
  parameter int unsigned ARENA_H    = 27,
  parameter int unsigned B_OFF_X    = 8,
  parameter int unsigned B_OFF_Y    = 8,
  parameter int unsigned FUSE_TICKS = 75000000,
  parameter int unsigned EXP_TICKS  = 25000000,
  parameter int unsigned POST_TICKS = 2,
  parameter int unsigned EXP_LEN    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        display_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [9:0]  x_b,
  input  logic [9:0]  y_b,
  input  logic        place_btn,
  output logic        bomb_on,
  output logic        exp_on,
  output logic        post_exp_active,
  output logic        bomb_active,
  output logic [5:0]  exp_x_abm,
  output logic [5:0]  exp_y_abm,
  output logic [11:0] rgb_out
);

  typedef enum logic [1:0] {StIdle, StBomb, StExp, StPost} state_e;

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [5:0]  exp_x_q, exp_x_d, exp_y_q, exp_y_d;
  logic [1:0]  ext_u_q, ext_u_d, ext_r_q, ext_r_d, ext_d_q, ext_d_d, ext_l_q, ext_l_d;
  logic        btn_q;
  logic        btn_edge;

  logic [9:0]  bsum_x, bsum_y, psum_x, psum_y;
  logic [5:0]  tile_bx, tile_by, px, py;
  logic        pix_in;
  logic        unused_bits;

  // Tile index is the upper six bits of the 10-bit wall-relative offset.
  assign bsum_x  = x_b + 10'(B_OFF_X) - 10'(X_WALL_L);
  assign bsum_y  = y_b + 10'(B_OFF_Y) - 10'(Y_WALL_U);
  assign tile_bx = bsum_x[9:4];
  assign tile_by = bsum_y[9:4];
  assign psum_x  = x - 10'(X_WALL_L);
  assign psum_y  = y - 10'(Y_WALL_U);
  assign px      = psum_x[9:4];
  assign py      = psum_y[9:4];
  assign pix_in  = (x >= 10'(X_WALL_L)) && (y >= 10'(Y_WALL_U));
  assign unused_bits = ^{bsum_x[3:0], bsum_y[3:0], psum_x[3:0], psum_y[3:0], 32'(TILE_WH)};

  assign btn_edge = place_btn & ~btn_q;

  // Count reachable tiles; signed walk so an arm at coordinate 0 cannot wrap.
  function automatic logic [1:0] arm_ext(input int cx, input int cy, input int dx, input int dy);
    logic [1:0] n;
    logic       stop;
    int         tx, ty;
    n    = 2'd0;
    stop = 1'b0;
    for (int k = 1; k <= int'(EXP_LEN); k++) begin
      tx = cx + k * dx;
      ty = cy + k * dy;
      if (tx < 0 || tx >= int'(ARENA_W) || ty < 0 || ty >= int'(ARENA_H) || (tx[0] && ty[0])) begin
        stop = 1'b1;
      end
      if (!stop) n = n + 2'd1;
    end
    return n;
  endfunction

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    exp_x_d = exp_x_q;
    exp_y_d = exp_y_q;
    ext_u_d = ext_u_q;
    ext_r_d = ext_r_q;
    ext_d_d = ext_d_q;
    ext_l_d = ext_l_q;
    unique case (state_q)
      StIdle: begin
        if (btn_edge) begin
          exp_x_d = tile_bx;
          exp_y_d = tile_by;
          timer_d = 32'd0;
          state_d = StBomb;
        end
      end
      StBomb: begin
        if (timer_q == 32'(FUSE_TICKS - 1)) begin
          timer_d = 32'd0;
          ext_u_d = arm_ext(int'(exp_x_q), int'(exp_y_q), 0, -1);
          ext_r_d = arm_ext(int'(exp_x_q), int'(exp_y_q), 1, 0);
          ext_d_d = arm_ext(int'(exp_x_q), int'(exp_y_q), 0, 1);
          ext_l_d = arm_ext(int'(exp_x_q), int'(exp_y_q), -1, 0);
          state_d = StExp;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      StExp: begin
        if (timer_q == 32'(EXP_TICKS - 1)) begin
          timer_d = 32'd0;
          state_d = StPost;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      StPost: begin
        if (timer_q == 32'(POST_TICKS - 1)) begin
          timer_d = 32'd0;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      timer_q <= 32'd0;
      exp_x_q <= 6'd0;
      exp_y_q <= 6'd0;
      ext_u_q <= 2'd0;
      ext_r_q <= 2'd0;
      ext_d_q <= 2'd0;
      ext_l_q <= 2'd0;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      exp_x_q <= exp_x_d;
      exp_y_q <= exp_y_d;
      ext_u_q <= ext_u_d;
      ext_r_q <= ext_r_d;
      ext_d_q <= ext_d_d;
      ext_l_q <= ext_l_d;
      btn_q   <= place_btn;
    end
  end

  logic same_col, same_row, hit_u, hit_d, hit_l, hit_r;
  logic [5:0] dist_u, dist_d, dist_l, dist_r;

  assign dist_u   = exp_y_q - py;
  assign dist_d   = py - exp_y_q;
  assign dist_l   = exp_x_q - px;
  assign dist_r   = px - exp_x_q;
  assign same_col = (px == exp_x_q);
  assign same_row = (py == exp_y_q);
  assign hit_u    = same_col && (py < exp_y_q) && (dist_u <= {4'd0, ext_u_q});
  assign hit_d    = same_col && (py > exp_y_q) && (dist_d <= {4'd0, ext_d_q});
  assign hit_l    = same_row && (px < exp_x_q) && (dist_l <= {4'd0, ext_l_q});
  assign hit_r    = same_row && (px > exp_x_q) && (dist_r <= {4'd0, ext_r_q});

  assign exp_on = (state_q == StExp) && display_on && pix_in &&
                  ((same_col && same_row) || hit_u || hit_d || hit_l || hit_r);
  assign bomb_on = (state_q == StBomb) && display_on && pix_in && same_col && same_row;

  assign post_exp_active = (state_q == StPost);
  assign bomb_active     = (state_q != StIdle);
  assign exp_x_abm       = exp_x_q;
  assign exp_y_abm       = exp_y_q;
  assign rgb_out         = exp_on ? 12'hF80 : (bomb_on ? 12'h222 : 12'h000);

endmodule

// File: tb/tb_bomb_exp_module.sv
// Directed bench for bomb_exp_module with short timers; expectations queued at drive time.
`timescale 1ns/1ps
module tb_bomb_exp_module;

  logic        clk = 1'b0;
  logic        reset;
  logic        display_on;
  logic [9:0]  x, y, x_b, y_b;
  logic        place_btn;
  logic        bomb_on, exp_on, post_exp_active, bomb_active;
  logic [5:0]  exp_x_abm, exp_y_abm;
  logic [11:0] rgb_out;

  int n_pass  = 0;
  int n_total = 0;
  string       tag_q[$];
  logic [15:0] val_q[$];

  always #50 clk = ~clk;

  bomb_exp_module #(
    .FUSE_TICKS(10),
    .EXP_TICKS (5),
    .POST_TICKS(2),
    .EXP_LEN   (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .display_on     (display_on),
    .x              (x),
    .y              (y),
    .x_b            (x_b),
    .y_b            (y_b),
    .place_btn      (place_btn),
    .bomb_on        (bomb_on),
    .exp_on         (exp_on),
    .post_exp_active(post_exp_active),
    .bomb_active    (bomb_active),
    .exp_x_abm      (exp_x_abm),
    .exp_y_abm      (exp_y_abm),
    .rgb_out        (rgb_out)
  );

  task automatic push(input string tag, input logic [15:0] val);
    tag_q.push_back(tag);
    val_q.push_back(val);
  endtask

  task automatic check(input logic [15:0] obs);
    string       t;
    logic [15:0] e;
    t = tag_q.pop_front();
    e = val_q.pop_front();
    n_total++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s: observed %h expected %h", t, obs, e);
  endtask

  task automatic expect_now(input string tag, input logic [15:0] obs, input logic [15:0] e);
    push(tag, e);
    check(obs);
  endtask

  // Point at a tile's top-left pixel and compare exp_on.
  task automatic pix(input int tx, input int ty, input logic e, input string tag);
    x = 10'(48 + 16 * tx);
    y = 10'(31 + 16 * ty);
    push(tag, {15'd0, e});
    #1;
    check({15'd0, exp_on});
  endtask

  task automatic bpix(input int xv, input int yv, input logic e, input string tag);
    x = 10'(xv);
    y = 10'(yv);
    push(tag, {15'd0, e});
    #1;
    check({15'd0, bomb_on});
  endtask

  // Returns on the negedge right after the placement clock edge.
  task automatic place(input int tx, input int ty, input bit hold);
    x_b = 10'(48 + 16 * tx - 8);
    y_b = 10'(31 + 16 * ty - 8);
    place_btn = 1'b1;
    @(negedge clk);
    if (!hold) place_btn = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bomb_active && n < 40) begin
      @(negedge clk);
      n++;
    end
    push("return_to_idle", 16'd0);
    check({15'd0, bomb_active});
  endtask

  initial begin
    int first_exp, exp_cnt, post_cnt;
    reset = 1'b0; display_on = 1'b1; place_btn = 1'b0;
    x = '0; y = '0; x_b = '0; y_b = '0;
    #5;
    expect_now("rst_bomb_active", {15'd0, bomb_active}, 16'd0);
    expect_now("rst_post", {15'd0, post_exp_active}, 16'd0);
    expect_now("rst_exp_on", {15'd0, exp_on}, 16'd0);
    expect_now("rst_bomb_on", {15'd0, bomb_on}, 16'd0);
    expect_now("rst_rgb", {4'd0, rgb_out}, 16'h0000);
    expect_now("rst_exp_x", {10'd0, exp_x_abm}, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Placement at tile (4,2) and bomb pixel window.
    place(4, 2, 0);
    expect_now("place_active", {15'd0, bomb_active}, 16'd1);
    expect_now("place_x", {10'd0, exp_x_abm}, 16'd4);
    expect_now("place_y", {10'd0, exp_y_abm}, 16'd2);
    bpix(112, 63, 1, "bomb_tl");
    expect_now("bomb_rgb", {4'd0, rgb_out}, 16'h0222);
    bpix(127, 78, 1, "bomb_br");
    bpix(128, 70, 0, "bomb_right_out");
    bpix(111, 70, 0, "bomb_left_out");
    bpix(120, 79, 0, "bomb_below_out");
    bpix(120, 62, 0, "bomb_above_out");

    // Second press during bomb is ignored.
    x_b = 10'(48 + 16 * 7 - 8);
    y_b = 10'(31 + 16 * 7 - 8);
    place_btn = 1'b1;
    @(negedge clk);
    place_btn = 1'b0;
    @(negedge clk);
    expect_now("repress_x", {10'd0, exp_x_abm}, 16'd4);
    expect_now("repress_y", {10'd0, exp_y_abm}, 16'd2);

    // Phase timing measured in negedges after the placement edge.
    x = 10'd112; y = 10'd63;
    first_exp = -1; exp_cnt = 0; post_cnt = 0;
    for (int k = 3; k <= 30; k++) begin
      @(negedge clk);
      if (k == 11) place_btn = 1'b1;
      if (k == 12) place_btn = 1'b0;
      if (exp_on && first_exp < 0) first_exp = k;
      exp_cnt  += int'(exp_on);
      post_cnt += int'(post_exp_active);
    end
    expect_now("exp_start", 16'(first_exp), 16'd10);
    expect_now("exp_len", 16'(exp_cnt), 16'd5);
    expect_now("post_len", 16'(post_cnt), 16'd2);
    expect_now("idle_after", {15'd0, bomb_active}, 16'd0);
    expect_now("press_in_exp_x", {10'd0, exp_x_abm}, 16'd4);

    // Bomb at (2,2): full arms, pillar (3,3) off-axis.
    place(2, 2, 0);
    repeat (10) @(negedge clk);
    pix(2, 2, 1, "c22_centre");
    expect_now("exp_rgb", {4'd0, rgb_out}, 16'h0F80);
    pix(2, 0, 1, "c22_up2");
    pix(2, 4, 1, "c22_down2");
    pix(0, 2, 1, "c22_left2");
    pix(4, 2, 1, "c22_right2");
    pix(3, 2, 1, "c22_right1");
    pix(2, 5, 0, "c22_down3");
    pix(5, 2, 0, "c22_right3");
    pix(3, 3, 0, "c22_diag");
    display_on = 1'b0;
    pix(2, 2, 0, "c22_blank");
    display_on = 1'b1;
    wait_idle();

    // Bomb at (1,2): vertical neighbours are pillars.
    place(1, 2, 0);
    repeat (10) @(negedge clk);
    pix(1, 1, 0, "c12_up_pillar");
    pix(1, 0, 0, "c12_up2");
    pix(1, 3, 0, "c12_down_pillar");
    pix(0, 2, 1, "c12_left");
    pix(3, 2, 1, "c12_right2");
    wait_idle();

    // Bomb at (0,0) with button held through the whole cycle.
    place(0, 0, 1);
    expect_now("c00_x", {10'd0, exp_x_abm}, 16'd0);
    expect_now("c00_y", {10'd0, exp_y_abm}, 16'd0);
    repeat (10) @(negedge clk);
    pix(0, 0, 1, "c00_centre");
    pix(32, 0, 0, "c00_no_wrap_x");
    pix(0, 26, 0, "c00_no_wrap_y");
    pix(1, 0, 1, "c00_right");
    pix(0, 2, 1, "c00_down2");
    pix(0, 3, 0, "c00_down3");
    x = 10'd47; y = 10'd31;
    push("c00_left_of_wall", 16'd0);
    #1;
    check({15'd0, exp_on});
    wait_idle();
    repeat (5) @(negedge clk);
    expect_now("held_no_replace", {15'd0, bomb_active}, 16'd0);
    place_btn = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-explosion.
    place(4, 2, 0);
    repeat (10) @(negedge clk);
    pix(4, 2, 1, "pre_reset_exp");
    reset = 1'b0;
    #1;
    expect_now("reset_exp_on", {15'd0, exp_on}, 16'd0);
    expect_now("reset_post", {15'd0, post_exp_active}, 16'd0);
    expect_now("reset_active", {15'd0, bomb_active}, 16'd0);
    expect_now("reset_rgb", {4'd0, rgb_out}, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    expect_now("post_reset_idle", {15'd0, bomb_active}, 16'd0);
    expect_now("post_reset_x", {10'd0, exp_x_abm}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
